// File: rtl/semaphore_monitor_if.sv
// semaphore_monitor_if: lamp bus, control, read port and status of the monitor.
// master drives sm_sig/clear/rd_en/rd_addr; slave (the monitor) drives the rest.
interface semaphore_monitor_if #(
   parameter int NMB_SIG_SEMAPHORE = 3
);
   logic [NMB_SIG_SEMAPHORE-1:0] sm_sig;
   logic                         clear;
   logic                         rd_en;
   logic [3:0]                   rd_addr;
   logic [7:0]                   rd_data;
   logic                         rd_valid;
   logic [1:0]                   phase;
   logic                         phase_valid;
   logic                         cycle_done;
   logic                         err_seq;
   logic                         err_illegal;
   logic                         err_stuck;

   modport master (
      output sm_sig,
      output clear,
      output rd_en,
      output rd_addr,
      input  rd_data,
      input  rd_valid,
      input  phase,
      input  phase_valid,
      input  cycle_done,
      input  err_seq,
      input  err_illegal,
      input  err_stuck
   );

   modport slave (
      input  sm_sig,
      input  clear,
      input  rd_en,
      input  rd_addr,
      output rd_data,
      output rd_valid,
      output phase,
      output phase_valid,
      output cycle_done,
      output err_seq,
      output err_illegal,
      output err_stuck
   );
endinterface

// File: rtl/semaphore_monitor.sv
// semaphore_monitor: receive-side checker for the traffic-light lamp bus.
// Ports: clk; reset (sync, active-high); mon (semaphore_monitor_if.slave):
//   in  sm_sig, clear, rd_en, rd_addr
//   out rd_data, rd_valid, phase, phase_valid, cycle_done,
//       err_seq, err_illegal, err_stuck
module semaphore_monitor #(
   parameter int NMB_STATE_SEM = 4,
   parameter int TIMEOUT       = 1024
) (
   input  logic               clk,
   input  logic               reset,
   semaphore_monitor_if.slave mon
);

   localparam int NMB_SIG_SEMAPHORE = 3;
   localparam int RED    = 0;
   localparam int YELLOW = 1;
   localparam int GREEN  = 2;

   typedef logic [NMB_SIG_SEMAPHORE-1:0] sig_t;
   typedef logic [3:0] u4_t;
   typedef logic [7:0] u8_t;
   typedef enum logic {ACQUIRE, TRACK} state_t;

   localparam sig_t PAT_R  = sig_t'(1 << RED);
   localparam sig_t PAT_RY = sig_t'((1 << RED) | (1 << YELLOW));
   localparam sig_t PAT_G  = sig_t'(1 << GREEN);
   localparam sig_t PAT_Y  = sig_t'(1 << YELLOW);

   localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

   // {legal, phase} of a lamp pattern
   function automatic logic [2:0] decode(input sig_t pat);
      unique case (1'b1)
         (pat == PAT_R):  decode = {1'b1, 2'd0};
         (pat == PAT_RY): decode = {1'b1, 2'd1};
         (pat == PAT_G):  decode = {1'b1, 2'd2};
         (pat == PAT_Y):  decode = {1'b1, 2'd3};
         default:         decode = 3'b000;
      endcase
   endfunction

   state_t      state;
   sig_t        cur_pat;
   logic        primed;
   logic [15:0] dwell_cnt;
   u8_t         dwell [NMB_STATE_SEM];
   u8_t         cycle_cnt;

   logic [1:0]  phase_q;
   logic        pv_q;
   logic        done_q;
   logic        seq_q;
   logic        ill_q;
   logic        stuck_q;

   logic        rd_valid_q;
   u8_t         rd_data_q;

   logic        new_ok;
   logic [1:0]  new_ph;
   logic        cur_ok;
   logic [1:0]  cur_ph;
   logic        changed;
   logic        act;
   logic        succ;
   logic [15:0] dwell_nxt;
   logic [15:0] dwell_m1;
   u8_t         dwell_sat;
   logic        set_ill;
   logic        set_seq;
   logic        set_stuck;
   logic        done_hit;
   logic        store;

   u4_t         rd_addr;
   u8_t         status;
   u8_t         rd_mux;

   assign {new_ok, new_ph} = decode(mon.sm_sig);
   assign {cur_ok, cur_ph} = decode(cur_pat);

   assign changed = mon.sm_sig != cur_pat;
   assign act     = primed & changed;
   assign succ    = cur_ok & new_ok & (new_ph == cur_ph + 2'd1);

   always_comb begin
      dwell_nxt = 16'd1;
      if (!changed) begin
         dwell_nxt = (dwell_cnt == 16'hFFFF) ? dwell_cnt
                                             : dwell_cnt + 16'd1;
      end
   end

   // stored dwell is the programmed delay: a phase lasts D+1 samples
   assign dwell_m1  = dwell_cnt - 16'd1;
   assign dwell_sat = (|dwell_m1[15:8]) ? 8'hFF : dwell_m1[7:0];

   assign set_ill   = act & ~new_ok;
   assign set_seq   = act & new_ok & ~succ & (state == TRACK);
   assign store     = act & succ & (state == TRACK);
   assign done_hit  = store & (cur_ph == 2'd3);
   // flag raised on the edge at which dwell_cnt reaches TIMEOUT
   assign set_stuck = primed & (dwell_nxt == TO_CNT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ACQUIRE;
         cur_pat   <= '0;
         primed    <= 1'b0;
         dwell_cnt <= 16'd1;
         cycle_cnt <= '0;
         phase_q   <= '0;
         pv_q      <= 1'b0;
         done_q    <= 1'b0;
         seq_q     <= 1'b0;
         ill_q     <= 1'b0;
         stuck_q   <= 1'b0;
         for (int i = 0; i < NMB_STATE_SEM; i++) begin
            dwell[i] <= '0;
         end
      end else begin
         if (!primed) begin
            // first sample after reset only seeds the pattern
            primed  <= 1'b1;
            cur_pat <= mon.sm_sig;
         end else begin
            dwell_cnt <= dwell_nxt;
            if (changed) begin
               cur_pat <= mon.sm_sig;
               if (!new_ok) begin
                  state <= ACQUIRE;
                  pv_q  <= 1'b0;
               end else if (succ) begin
                  state   <= TRACK;
                  pv_q    <= 1'b1;
                  phase_q <= new_ph;
                  if (state == TRACK) begin
                     dwell[cur_ph] <= dwell_sat;
                  end
               end else begin
                  state   <= ACQUIRE;
                  pv_q    <= 1'b0;
                  phase_q <= new_ph;
               end
            end
         end

         done_q  <= done_hit;
         seq_q   <= set_seq   | (seq_q   & ~mon.clear);
         ill_q   <= set_ill   | (ill_q   & ~mon.clear);
         stuck_q <= set_stuck | (stuck_q & ~mon.clear);

         if (done_hit) begin
            cycle_cnt <= mon.clear ? 8'd1 : cycle_cnt + 8'd1;
         end else if (mon.clear) begin
            cycle_cnt <= '0;
         end
      end
   end

   assign rd_addr = mon.rd_addr;
   assign status  = {2'b00, stuck_q, ill_q, seq_q, pv_q, phase_q};

   always_comb begin
      rd_mux = '0;
      unique case (1'b1)
         (rd_addr < 4'd4):  rd_mux = dwell[rd_addr[1:0]];
         (rd_addr == 4'd4): rd_mux = status;
         (rd_addr == 4'd5): rd_mux = cycle_cnt;
         default:           rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= mon.rd_en;
         if (mon.rd_en) begin
            rd_data_q <= rd_mux;
         end
      end
   end

   assign mon.rd_data     = rd_data_q;
   assign mon.rd_valid    = rd_valid_q;
   assign mon.phase       = phase_q;
   assign mon.phase_valid = pv_q;
   assign mon.cycle_done  = done_q;
   assign mon.err_seq     = seq_q;
   assign mon.err_illegal = ill_q;
   assign mon.err_stuck   = stuck_q;

endmodule
